// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch controller with a single outstanding
// instruction-memory request, decode-side valid/ready handshake, flush
// redirect and misaligned-PC error trapping.
//
// Handshake: Instr/PC are offered while instr_valid=1 and are held stable
// until the cycle where instr_valid && instr_ready, which is the transfer;
// instr_valid never drops without a transfer except on flush or rst.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   PCSrc               next-PC select at handshake (00 +4, 01 target, 10 Result, 11 refetch)
//   PC_target, Result   redirect sources for PCSrc 01 / 10
//   flush, flush_pc     highest-priority redirect
//   imem_req/imem_addr  one-cycle read strobe and address (= PC)
//   imem_rvalid/rdata   read response, one pulse per request
//   Instr, PC, pc_out4  fetched word, its address, PC+4
//   instr_valid/ready   decode handshake
//   fetch_err           misaligned PC, held until flush
//   o_dbg_state         current FSM state encoding
//   perf_fetch_cnt, perf_stall_cnt   only with FETCH_CTRL_PERF_EN defined
//
// Optional feature macro: FETCH_CTRL_PERF_EN (handshake and stall counters).
module fetch_ctrl #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            PCSrc,
    input  logic [DATA_WIDTH-1:0] PC_target,
    input  logic [DATA_WIDTH-1:0] Result,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] flush_pc,
    output logic                  imem_req,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic                  imem_rvalid,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic [DATA_WIDTH-1:0] Instr,
    output logic [DATA_WIDTH-1:0] PC,
    output logic [DATA_WIDTH-1:0] pc_out4,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic                  fetch_err,
`ifdef FETCH_CTRL_PERF_EN
    output logic [31:0]           perf_fetch_cnt,
    output logic [31:0]           perf_stall_cnt,
`endif
    output logic [2:0]            o_dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_VALID = 3'd3,
        S_DRAIN = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    localparam logic [DATA_WIDTH-1:0] PC_INC = DATA_WIDTH'(4);

    state_t                r_state;
    state_t                w_state_next;
    logic [DATA_WIDTH-1:0] r_pc;
    logic [DATA_WIDTH-1:0] w_pc_next;
    logic [DATA_WIDTH-1:0] r_instr;
    logic [DATA_WIDTH-1:0] w_pc_plus4;
    logic [DATA_WIDTH-1:0] w_sel_pc;
    logic                  w_handshake;
    logic                  w_instr_load;

    assign w_pc_plus4  = r_pc + PC_INC;
    assign w_handshake = (r_state == S_VALID) && instr_ready;

    always_comb begin
        w_sel_pc = w_pc_plus4;
        case (PCSrc)
            2'b00:   w_sel_pc = w_pc_plus4;
            2'b01:   w_sel_pc = PC_target;
            2'b10:   w_sel_pc = Result;
            default: w_sel_pc = r_pc;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_instr_load = 1'b0;
        if (flush) begin
            // Flush wins over handshake and response; a response still owed
            // by memory must be drained before a new request goes out.
            w_pc_next = flush_pc;
            if (flush_pc[1:0] != 2'b00) begin
                w_state_next = S_ERR;
            end else if ((r_state == S_WAIT || r_state == S_DRAIN) && !imem_rvalid) begin
                w_state_next = S_DRAIN;
            end else begin
                w_state_next = S_REQ;
            end
        end else begin
            case (r_state)
                S_IDLE:  w_state_next = S_REQ;
                S_REQ:   w_state_next = S_WAIT;
                S_WAIT: begin
                    if (imem_rvalid) begin
                        w_instr_load = 1'b1;
                        w_state_next = S_VALID;
                    end
                end
                S_VALID: begin
                    if (w_handshake) begin
                        w_pc_next    = w_sel_pc;
                        w_state_next = (w_sel_pc[1:0] != 2'b00) ? S_ERR : S_REQ;
                    end
                end
                S_DRAIN: begin
                    if (imem_rvalid) begin
                        w_state_next = S_REQ;
                    end
                end
                S_ERR:   w_state_next = S_ERR;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_PC;
            r_instr <= '0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            if (w_instr_load) begin
                r_instr <= imem_rdata;
            end
        end
    end

`ifdef FETCH_CTRL_PERF_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            // A handshake overridden by flush is not a delivered fetch.
            if (w_handshake && !flush) begin
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end
            if (r_state == S_WAIT || r_state == S_DRAIN) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt = r_fetch_cnt;
    assign perf_stall_cnt = r_stall_cnt;
`endif

    assign imem_req    = (r_state == S_REQ);
    assign imem_addr   = r_pc;
    assign PC          = r_pc;
    assign pc_out4     = w_pc_plus4;
    assign Instr       = r_instr;
    assign instr_valid = (r_state == S_VALID);
    assign fetch_err   = (r_state == S_ERR);
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: a latency-programmable memory responder, a driver
// that plays the decode stage, and a monitor that pops expected fetch
// addresses and delivered {PC, Instr} pairs from queues as the DUT presents them.
module tb_fetch_ctrl;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [1:0]   PCSrc = 2'b00;
    logic [W-1:0] PC_target = '0;
    logic [W-1:0] Result = '0;
    logic         flush = 1'b0;
    logic [W-1:0] flush_pc = '0;
    logic         imem_rvalid = 1'b0;
    logic [W-1:0] imem_rdata = '0;
    logic         instr_ready = 1'b0;
    logic         imem_req;
    logic [W-1:0] imem_addr;
    logic [W-1:0] Instr;
    logic [W-1:0] PC;
    logic [W-1:0] pc_out4;
    logic         instr_valid;
    logic         fetch_err;
    logic [2:0]   dbg_state;
`ifdef FETCH_CTRL_PERF_EN
    logic [31:0]  perf_fetch_cnt;
    logic [31:0]  perf_stall_cnt;
`endif

    fetch_ctrl #(.DATA_WIDTH(W), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .PCSrc(PCSrc), .PC_target(PC_target), .Result(Result),
        .flush(flush), .flush_pc(flush_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .Instr(Instr), .PC(PC),
        .pc_out4(pc_out4), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .fetch_err(fetch_err),
`ifdef FETCH_CTRL_PERF_EN
        .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt),
`endif
        .o_dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [W-1:0]   exp_addr_q[$];
    logic [2*W-1:0] exp_fetch_q[$];
    int lat = 1;
    int cur_lat = 1;
    logic [W-1:0] m_pc = '0;

    function automatic logic [W-1:0] mem_word(input logic [W-1:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Memory: returns mem_word(addr) 'lat' cycles after the request cycle.
    initial begin
        int cnt;
        logic [W-1:0] a;
        cnt = 0;
        a = '0;
        forever begin
            @(posedge clk);
            #1;
            imem_rvalid = 1'b0;
            if (rst) begin
                cnt = 0;
            end else begin
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        imem_rvalid = 1'b1;
                        imem_rdata  = mem_word(a);
                    end
                end
                if (imem_req) begin
                    cnt = lat;
                    cur_lat = lat;
                    a = imem_addr;
                end
            end
        end
    end

    // Monitor: checks every request address, every delivered word and the
    // request-to-valid latency.
    initial begin
        int since;
        logic pv;
        logic [2*W-1:0] e;
        since = 0;
        pv = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                since = 0;
                pv = 1'b0;
            end else begin
                if (imem_req) begin
                    since = 0;
                    if (exp_addr_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_req: got addr %h expected no request", imem_addr);
                    end else begin
                        check("imem_addr", imem_addr, exp_addr_q.pop_front());
                    end
                end else begin
                    since++;
                end
                if (instr_valid && !pv) begin
                    check("valid_latency", W'(since), W'(cur_lat + 1));
                end
                if (instr_valid && instr_ready) begin
                    if (exp_fetch_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_fetch: got PC %h expected none", PC);
                    end else begin
                        e = exp_fetch_q.pop_front();
                        check("fetch_PC", PC, e[2*W-1:W]);
                        check("fetch_Instr", Instr, e[W-1:0]);
                        check("pc_out4", pc_out4, e[2*W-1:W] + 32'd4);
                    end
                end
                pv = instr_valid;
            end
        end
    end

    task automatic wait_valid();
        int t;
        t = 0;
        while (!instr_valid && t < 60) begin
            step();
            t++;
        end
        checks++;
        if (!instr_valid) begin
            failures++;
            $display("FAIL wait_valid: got instr_valid 0 expected 1 within 60 cycles");
        end
    endtask

    // Decode stage: wait for a word, stall 'hold' cycles, then accept it.
    task automatic accept(input logic [1:0] src, input logic [W-1:0] tgt,
                          input logic [W-1:0] res, input int hold);
        logic [W-1:0] nxt;
        wait_valid();
        for (int i = 0; i < hold; i++) begin
            check("hold_PC", PC, m_pc);
            check("hold_Instr", Instr, mem_word(m_pc));
            step();
        end
        exp_fetch_q.push_back({m_pc, mem_word(m_pc)});
        case (src)
            2'b00:   nxt = m_pc + 32'd4;
            2'b01:   nxt = tgt;
            2'b10:   nxt = res;
            default: nxt = m_pc;
        endcase
        PCSrc = src;
        PC_target = tgt;
        Result = res;
        instr_ready = 1'b1;
        m_pc = nxt;
        if (nxt[1:0] == 2'b00) exp_addr_q.push_back(nxt);
        step();
        instr_ready = 1'b0;
    endtask

    initial begin
        int t;
        rst = 1'b1;
        step(3);
        check("rst_imem_req", W'(imem_req), 32'd0);
        check("rst_instr_valid", W'(instr_valid), 32'd0);
        check("rst_fetch_err", W'(fetch_err), 32'd0);
        check("rst_PC", PC, 32'h0000_0000);
        check("rst_Instr", Instr, 32'h0000_0000);

        m_pc = 32'h0;
        exp_addr_q.push_back(32'h0);
        rst = 1'b0;

        // Sequential fetches 0,4,8,C then redirects from 0x10.
        for (int i = 0; i < 4; i++) accept(2'b00, 32'h0, 32'h0, 0);
        accept(2'b11, 32'h0, 32'h0, 0);          // refetch 0x10
        accept(2'b01, 32'h40, 32'h0, 0);         // 0x10 -> 0x40
        accept(2'b10, 32'h0, 32'h80, 5);         // stall 5 cycles, then -> 0x80

        // Flush while waiting on a slow response.
        lat = 4;
        accept(2'b00, 32'h0, 32'h0, 0);          // request 0x84
        t = 0;
        while (!imem_req && t < 10) begin step(); t++; end
        step();
        check("flush_in_wait_state", W'(dbg_state), 32'd2);
        flush = 1'b1;
        flush_pc = 32'h100;
        lat = 1;
        exp_addr_q.push_back(32'h100);
        m_pc = 32'h100;
        step();
        flush = 1'b0;
        check("flush_PC", PC, 32'h100);
        for (int i = 0; i < 4; i++) begin
            check("drain_no_valid", W'(instr_valid), 32'd0);
            step();
        end

        // Misaligned redirect, then recovery by flush.
        accept(2'b01, 32'h42, 32'h0, 0);
        for (int i = 0; i < 3; i++) begin
            check("err_fetch_err", W'(fetch_err), 32'd1);
            check("err_instr_valid", W'(instr_valid), 32'd0);
            check("err_PC", PC, 32'h42);
            step();
        end
        flush = 1'b1;
        flush_pc = 32'h200;
        exp_addr_q.push_back(32'h200);
        m_pc = 32'h200;
        step();
        flush = 1'b0;
        check("recover_fetch_err", W'(fetch_err), 32'd0);
        check("recover_imem_req", W'(imem_req), 32'd1);
        accept(2'b00, 32'h0, 32'h0, 0);
        wait_valid();
        check("addr_q_empty", W'(exp_addr_q.size()), 32'd0);
        check("fetch_q_empty", W'(exp_fetch_q.size()), 32'd0);

`ifdef FETCH_CTRL_PERF_EN
        rst = 1'b1;
        lat = 3;
        step(2);
        exp_addr_q.delete();
        exp_fetch_q.delete();
        m_pc = 32'h0;
        exp_addr_q.push_back(32'h0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) accept(2'b00, 32'h0, 32'h0, 0);
        check("perf_fetch_cnt", perf_fetch_cnt, 32'd4);
        check("perf_stall_cnt", perf_stall_cnt, 32'd12);
        step(2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
